// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: predecode opcodes, BHT counter type, saturating helpers.
package fetch_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_t;

  function automatic bht_ctr_t sat_inc(input bht_ctr_t c);
    case (c)
      SNT:     sat_inc = WNT;
      WNT:     sat_inc = WT;
      WT:      sat_inc = ST;
      ST:      sat_inc = ST;
      default: sat_inc = WNT;
    endcase
  endfunction

  function automatic bht_ctr_t sat_dec(input bht_ctr_t c);
    case (c)
      SNT:     sat_dec = SNT;
      WNT:     sat_dec = SNT;
      WT:      sat_dec = WNT;
      ST:      sat_dec = WT;
      default: sat_dec = WNT;
    endcase
  endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table: 2-bit saturating counters, one combinational read port, one clocked update port.
module fetch_bht
  import fetch_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int N = 1 << IDX_W;

  bht_ctr_t ctr_q [N];
  bht_ctr_t ctr_d [N];

  // Next-state of the counter array: only the written entry moves.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ctr_d[i] = ctr_q[i];
    end
    if (wr_en) begin
      ctr_d[wr_idx] = wr_taken ? sat_inc(ctr_q[wr_idx]) : sat_dec(ctr_q[wr_idx]);
    end else begin
      ctr_d[wr_idx] = ctr_q[wr_idx];
    end
  end

  // Counter storage; reset leaves every entry weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        ctr_q[i] <= WNT;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  // Reads see the pre-update value; no bypass from the write port.
  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/fetch_bp.sv
// Instruction fetch with predecode and optional 2-bit dynamic prediction.
// Define BRANCH_PRED_EN to build the BHT; otherwise beq/bne are always predicted not-taken.
module fetch_bp
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 7,
  parameter int                BHT_IDX_W = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              if_id_valid,
  output logic              if_id_pred_taken,
  output logic [ADDR_W-1:0] if_id_pred_target,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic              res_is_cond,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  input  logic              res_mispredict
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic              valid_q, valid_d;
  logic              pred_q, pred_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  logic [5:0]           opcode_s;
  logic [ADDR_W-1:0]    imm_s;
  logic [ADDR_W-1:0]    pc_inc_s;
  logic                 pred_taken_s;
  logic [ADDR_W-1:0]    pred_target_s;
  logic [BHT_IDX_W-1:0] bht_idx_s;
  logic [1:0]           bht_rd_s;
  logic                 unused_ok;

  assign opcode_s  = imem_data[31:26];
  assign imm_s     = imem_data[ADDR_W-1:0];
  assign pc_inc_s  = pc_q + ADDR_W'(1);
  assign bht_idx_s = pc_q[BHT_IDX_W-1:0];

`ifdef BRANCH_PRED_EN
  bht_ctr_t bht_ctr_s;

  fetch_bht #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk      (CLK),
    .rst      (RST),
    .rd_idx   (bht_idx_s),
    .rd_ctr   (bht_ctr_s),
    .wr_en    (res_valid & res_is_cond),
    .wr_idx   (res_pc[BHT_IDX_W-1:0]),
    .wr_taken (res_taken)
  );

  assign bht_rd_s = bht_ctr_s;
`else
  assign bht_rd_s = 2'b00;
`endif

  assign unused_ok = ^{imem_data[25:ADDR_W], res_is_cond, bht_idx_s, bht_rd_s};

  // Predecode: direct jumps always taken, conditional branches follow the BHT.
  always_comb begin
    pred_taken_s  = 1'b0;
    pred_target_s = pc_inc_s;
    case (opcode_s)
      OP_J: begin
        pred_taken_s  = 1'b1;
        pred_target_s = imm_s;
      end
      OP_BEQ, OP_BNE: begin
`ifdef BRANCH_PRED_EN
        pred_taken_s  = bht_rd_s[1];
        pred_target_s = pc_inc_s + imm_s;
`else
        pred_taken_s  = 1'b0;
        pred_target_s = pc_inc_s;
`endif
      end
      default: begin
        pred_taken_s  = 1'b0;
        pred_target_s = pc_inc_s;
      end
    endcase
  end

  // Next PC and IF/ID: EX redirect beats stall, stall beats normal fetch.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    pred_d  = pred_q;
    tgt_d   = tgt_q;
    if (res_valid && res_mispredict) begin
      pc_d    = res_taken ? res_target : (res_pc + ADDR_W'(1));
      valid_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d    = pred_taken_s ? pred_target_s : pc_inc_s;
      instr_d = imem_data;
      ifpc_d  = pc_q;
      valid_d = 1'b1;
      pred_d  = pred_taken_s;
      tgt_d   = pred_target_s;
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      pred_q  <= 1'b0;
      tgt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      pred_q  <= pred_d;
      tgt_q   <= tgt_d;
    end
  end

  assign imem_addr         = pc_q;
  assign if_id_instr       = instr_q;
  assign if_id_pc          = ifpc_q;
  assign if_id_valid       = valid_q;
  assign if_id_pred_taken  = pred_q;
  assign if_id_pred_target = tgt_q;

endmodule
